// File: rtl/mag_comparator_if.sv
// Operand/result bundle for mag_comparator; WIDTH must match the attached comparator.
// MAG_COMPARATOR_LT_EN adds the registered less-than flag.
interface mag_comparator_if #(
    parameter int unsigned WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             gt_in;
    logic             eq_in;
    logic             gt;
    logic             eq;
    logic             out_valid;
`ifdef MAG_COMPARATOR_LT_EN
    logic             lt;

    modport master (
        output in_valid, a, b, gt_in, eq_in,
        input  gt, eq, lt, out_valid
    );

    modport slave (
        input  in_valid, a, b, gt_in, eq_in,
        output gt, eq, lt, out_valid
    );
`else
    modport master (
        output in_valid, a, b, gt_in, eq_in,
        input  gt, eq, out_valid
    );

    modport slave (
        input  in_valid, a, b, gt_in, eq_in,
        output gt, eq, out_valid
    );
`endif
endinterface

// File: rtl/mag_comparator.sv
// Registered unsigned magnitude comparator built as an LSB-to-MSB ripple of per-bit cells.
// Optional MAG_COMPARATOR_LT_EN adds a registered lt flag.
module mag_comparator #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    mag_comparator_if.slave      bus
);

    logic gt_next;
    logic eq_next;

    logic gt_q, gt_d;
    logic eq_q, eq_d;
    logic valid_q, valid_d;

    // Later (more significant) cells overwrite the running decision, so the MSB dominates.
    always_comb begin
        logic g;
        logic e;
        logic x;
        g = bus.gt_in;
        e = bus.eq_in;
        x = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            x = ~(bus.a[i] ^ bus.b[i]);
            g = (bus.a[i] & ~bus.b[i]) | (x & g);
            e = x & e;
        end
        gt_next = g;
        eq_next = e;
    end

    always_comb begin
        gt_d    = gt_q;
        eq_d    = eq_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            gt_d = gt_next;
            eq_d = eq_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gt_q    <= 1'b0;
            eq_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            gt_q    <= gt_d;
            eq_q    <= eq_d;
            valid_q <= valid_d;
        end
    end

    assign bus.gt        = gt_q;
    assign bus.eq        = eq_q;
    assign bus.out_valid = valid_q;

`ifdef MAG_COMPARATOR_LT_EN
    logic lt_q, lt_d;

    always_comb begin
        lt_d = lt_q;
        if (bus.in_valid) begin
            lt_d = ~gt_next & ~eq_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt_q <= 1'b0;
        end else begin
            lt_q <= lt_d;
        end
    end

    assign bus.lt = lt_q;
`endif

endmodule

// File: tb/tb_mag_comparator.sv
// Directed-vector bench for mag_comparator (WIDTH=4); checks lt too when MAG_COMPARATOR_LT_EN is defined.
module tb_mag_comparator;

    logic clk;
    logic rst_n;
    int   vectors;
    int   misses;

    mag_comparator_if #(.WIDTH(4)) bus ();

    mag_comparator #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, return 1 time unit after the capturing rising edge.
    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                         input logic gi, input logic ei);
        @(negedge clk);
        bus.in_valid = v;
        bus.a        = av;
        bus.b        = bv;
        bus.gt_in    = gi;
        bus.eq_in    = ei;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.gt_in    = 1'b0;
        bus.eq_in    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.a        = 4'($urandom_range(0, 15));
            bus.b        = 4'($urandom_range(0, 15));
        end
        @(posedge clk);
        #1;
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL reset_gt: got %b expected 0", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL reset_eq: got %b expected 0", bus.eq); misses++; end
        vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL reset_ov: got %b expected 0", bus.out_valid); misses++; end
`ifdef MAG_COMPARATOR_LT_EN
        vectors++; if (bus.lt !== 1'b0) begin $display("FAIL reset_lt: got %b expected 0", bus.lt); misses++; end
`endif
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b1;
        drive(1'b0, 4'd3, 4'd3, 1'b0, 1'b1);
        drive(1'b0, 4'd3, 4'd3, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL post_reset_gt: got %b expected 0", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL post_reset_eq: got %b expected 0", bus.eq); misses++; end
        vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL post_reset_ov: got %b expected 0", bus.out_valid); misses++; end
    endtask

    task automatic test_less_than;
        drive(1'b1, 4'b0101, 4'b0111, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL lt_gt: got %b expected 0", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL lt_eq: got %b expected 0", bus.eq); misses++; end
        vectors++; if (bus.out_valid !== 1'b1) begin $display("FAIL lt_ov: got %b expected 1", bus.out_valid); misses++; end
`ifdef MAG_COMPARATOR_LT_EN
        vectors++; if (bus.lt !== 1'b1) begin $display("FAIL lt_lt: got %b expected 1", bus.lt); misses++; end
`endif
    endtask

    task automatic test_equal;
        drive(1'b1, 4'b1101, 4'b1101, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL eq13_gt: got %b expected 0", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b1) begin $display("FAIL eq13_eq: got %b expected 1", bus.eq); misses++; end
`ifdef MAG_COMPARATOR_LT_EN
        vectors++; if (bus.lt !== 1'b0) begin $display("FAIL eq13_lt: got %b expected 0", bus.lt); misses++; end
`endif
        drive(1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL eq0_gt: got %b expected 0", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b1) begin $display("FAIL eq0_eq: got %b expected 1", bus.eq); misses++; end
    endtask

    task automatic test_msb_dominates;
        drive(1'b1, 4'b1000, 4'b0101, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b1) begin $display("FAIL msb85_gt: got %b expected 1", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL msb85_eq: got %b expected 0", bus.eq); misses++; end
        drive(1'b1, 4'b1000, 4'b0111, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b1) begin $display("FAIL msb87_gt: got %b expected 1", bus.gt); misses++; end
        drive(1'b1, 4'b0111, 4'b1000, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL msb78_gt: got %b expected 0", bus.gt); misses++; end
        drive(1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b1) begin $display("FAIL ones_gt: got %b expected 1", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL ones_eq: got %b expected 0", bus.eq); misses++; end
    endtask

    task automatic test_cascade;
        drive(1'b1, 4'b0011, 4'b0011, 1'b1, 1'b0);
        vectors++; if (bus.gt !== 1'b1) begin $display("FAIL casc_gt_gt: got %b expected 1", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL casc_gt_eq: got %b expected 0", bus.eq); misses++; end
        drive(1'b1, 4'b0011, 4'b0011, 1'b0, 1'b0);
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL casc_lt_gt: got %b expected 0", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL casc_lt_eq: got %b expected 0", bus.eq); misses++; end
        drive(1'b1, 4'b0110, 4'b0110, 1'b1, 1'b1);
        vectors++; if (bus.gt !== 1'b1) begin $display("FAIL casc_both_gt: got %b expected 1", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b1) begin $display("FAIL casc_both_eq: got %b expected 1", bus.eq); misses++; end
        // A greater slice still loses to a higher bit where b wins.
        drive(1'b1, 4'b0100, 4'b1000, 1'b1, 1'b0);
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL casc_msb_gt: got %b expected 0", bus.gt); misses++; end
        drive(1'b1, 4'b1001, 4'b1001, 1'b0, 1'b1);
        drive(1'b0, 4'b0001, 4'b1110, 1'b0, 1'b1);
        vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL idle_ov: got %b expected 0", bus.out_valid); misses++; end
        vectors++; if (bus.eq !== 1'b1) begin $display("FAIL idle_eq_hold: got %b expected 1", bus.eq); misses++; end
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL idle_gt_hold: got %b expected 0", bus.gt); misses++; end
        drive(1'b1, 4'b1100, 4'b0011, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b1) begin $display("FAIL idle_gt_hold2: got %b expected 1", bus.gt); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL idle_eq_hold2: got %b expected 0", bus.eq); misses++; end
    endtask

    task automatic test_midstream_reset;
        drive(1'b1, 4'd1, 4'd2, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b0 || bus.eq !== 1'b0) begin $display("FAIL b2b0: got gt=%b eq=%b expected gt=0 eq=0", bus.gt, bus.eq); misses++; end
        drive(1'b1, 4'd9, 4'd3, 1'b0, 1'b1);
        vectors++; if (bus.gt !== 1'b1 || bus.out_valid !== 1'b1) begin $display("FAIL b2b1: got gt=%b ov=%b expected gt=1 ov=1", bus.gt, bus.out_valid); misses++; end
        drive(1'b1, 4'd4, 4'd4, 1'b0, 1'b1);
        vectors++; if (bus.eq !== 1'b1 || bus.out_valid !== 1'b1) begin $display("FAIL b2b2: got eq=%b ov=%b expected eq=1 ov=1", bus.eq, bus.out_valid); misses++; end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if (bus.out_valid !== 1'b0) begin $display("FAIL mid_rst_ov: got %b expected 0", bus.out_valid); misses++; end
        vectors++; if (bus.eq !== 1'b0) begin $display("FAIL mid_rst_eq: got %b expected 0", bus.eq); misses++; end
        vectors++; if (bus.gt !== 1'b0) begin $display("FAIL mid_rst_gt: got %b expected 0", bus.gt); misses++; end
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        vectors++; if (bus.out_valid !== 1'b0 || bus.eq !== 1'b0 || bus.gt !== 1'b0)
            begin $display("FAIL mid_rst_release: got gt=%b eq=%b ov=%b expected all 0", bus.gt, bus.eq, bus.out_valid); misses++; end
    endtask

    initial begin
        vectors = 0;
        misses  = 0;
        test_reset();
        test_less_than();
        test_equal();
        test_msb_dominates();
        test_cascade();
        test_midstream_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule

// File: doc/mag_comparator.md
Name: mag_comparator

Overview:
- Registered unsigned magnitude comparator for two WIDTH-bit operands; default WIDTH=4.
- Built as a ripple cascade of per-bit cells running from bit 0 (LSB) to bit WIDTH-1 (MSB), so the MSB decision dominates.
- Produces greater-than and equal flags, registered one cycle after a valid input.
- Cascade inputs allow chaining several instances for wider words. Sits in datapath compare/branch logic.

Parameters:
- WIDTH, 4, operand width in bits; legal values 1..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands and cascade inputs are valid this cycle
- a  input  WIDTH  operand A, unsigned; a[0] is LSB
- b  input  WIDTH  operand B, unsigned
- gt_in  input  1  cascade greater-than from the less-significant slice; tie 0 when standalone
- eq_in  input  1  cascade equal from the less-significant slice; tie 1 when standalone
- gt  output  1  registered A>B, with cascade applied
- eq  output  1  registered A==B, with cascade applied
- out_valid  output  1  gt/eq hold a fresh result

Behaviour:
- Reset: rst_n low asynchronously forces gt=0, eq=0, out_valid=0 (lt=0 when enabled). Outputs hold these values until the first valid capture after rst_n rises.
- Per-bit cell i, with chain seeds g(-1)=gt_in and e(-1)=eq_in:
  - x_i = ~(a[i]^b[i])
  - e_i = x_i & e(i-1)
  - g_i = (a[i] & ~b[i]) | (x_i & g(i-1))
- Result: gt_next = g(WIDTH-1), eq_next = e(WIDTH-1). The chain is purely combinational, with no internal pipelining.
- Latency: when in_valid=1 at a clk rising edge, gt/eq are loaded from gt_next/eq_next and out_valid=1 after that edge.
- When in_valid=0 at an edge: gt/eq hold their previous values and out_valid=0.
- Back-to-back valids: one result per cycle; no stall, no ready signal.
- Cascade inputs with gt_in=1 and eq_in=1 (illegal): gt_in takes priority at equal bits. Result is gt=1 and eq=1 when a==b. This is not flagged as an error.
- Reset asserted mid-stream: the pending result is discarded; out_valid=0 immediately (asynchronous).
- Boundary cases:
  - All-zeros vs all-zeros with default cascade gives eq=1, gt=0.
  - All-ones vs all-zeros gives gt=1.
  - WIDTH=1 degenerates to a single cell.
- No X propagation on outputs after reset; inputs are sampled only on valid edges.

Optional Feature:
- Macro MAG_COMPARATOR_LT_EN.
- Defined:
  - Adds output port lt (1 bit), registered alongside gt/eq.
  - lt = ~gt_next & ~eq_next on valid edges; reset value 0.
- Undefined:
  - No lt port.
  - Less-than is inferred externally from gt=0 and eq=0.

Test Plan:
- Reset: hold rst_n=0 with random a/b/in_valid -> gt=0, eq=0, out_valid=0; release, in_valid=0 -> outputs stay 0.
- Less-than: a=4'b0101 (5), b=4'b0111 (7), gt_in=0, eq_in=1, in_valid=1 -> next cycle gt=0, eq=0, out_valid=1 (lt=1 if enabled).
- Equal: a=4'b1101, b=4'b1101 -> gt=0, eq=1; then a=b=0 -> eq=1.
- MSB dominates: a=4'b1000 (8) vs b=4'b0101 (5) -> gt=1, eq=0; a=4'b1000 vs b=4'b0111 -> gt=1.
- Cascade and handshake: a=b=4'b0011 with gt_in=1, eq_in=0 -> gt=1, eq=0. Then a=b with gt_in=0, eq_in=0 -> gt=0, eq=0. Then in_valid=0 for one cycle -> out_valid=0 and gt/eq held.
- Mid-stream reset: three back-to-back valid vectors, assert rst_n low between clock edges -> outputs clear immediately, no stale result after release.
